// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared constants and types for the LED scanner
package led_pkg;
  localparam int NLEDS       = 8;
  localparam int POS_W       = 3;
  localparam int PWM_W       = 2;
  localparam int DIV_DEFAULT = 1_200_000;
  localparam int DEB_DEFAULT = 120_000;

  typedef enum logic {
    RIGHT = 1'b0,
    LEFT  = 1'b1
  } dir_e;
endpackage

// File: rtl/btn_cond.sv
// rtl/btn_cond.sv - button synchronizer, debouncer and rising-edge pulse
module btn_cond #(
  parameter int DEB = 120_000
) (
  input  logic clk,
  input  logic rstn,
  input  logic in,
  output logic level,
  output logic rise
);
  localparam int CW = (DEB > 2) ? $clog2(DEB) : 1;

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          prev_q, rise_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // The level follows the synced input only after DEB consecutive mismatching cycles.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEB - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= in;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      prev_q  <= level_q;
      rise_q  <= level_q & ~prev_q;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
endmodule

// File: rtl/led_scanner.sv
// rtl/led_scanner.sv - bouncing LED scanner with 25% trail, run/pause and speed buttons
module led_scanner
  import led_pkg::*;
#(
  parameter int DIV = DIV_DEFAULT,
  parameter int DEB = DEB_DEFAULT
) (
  input  logic clk,
  input  logic rstn,
  input  logic sw1,
  input  logic sw2,
  output logic LED0,
  output logic LED1,
  output logic LED2,
  output logic LED3,
  output logic LED4,
  output logic LED5,
  output logic LED6,
  output logic LED7
);
  localparam int CW = $clog2(DIV);

  logic             sw1_lvl, sw1_rise, sw2_lvl, sw2_rise;
  logic             unused_levels;
  logic             run_q, run_d, fast_q, fast_d, tick;
  logic [CW-1:0]    cnt_q, cnt_d, last;
  dir_e             state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d, prev_q, prev_d;
  logic [PWM_W-1:0] pwm_q, pwm_d;
  logic [NLEDS-1:0] led_q, led_d;

  btn_cond #(.DEB(DEB)) u_btn1 (.clk(clk), .rstn(rstn), .in(sw1), .level(sw1_lvl), .rise(sw1_rise));
  btn_cond #(.DEB(DEB)) u_btn2 (.clk(clk), .rstn(rstn), .in(sw2), .level(sw2_lvl), .rise(sw2_rise));

  assign unused_levels = sw1_lvl ^ sw2_lvl;
  assign last = fast_q ? CW'(DIV / 4 - 1) : CW'(DIV - 1);
  assign tick = run_q & (cnt_q == last);

  always_comb begin
    run_d   = run_q ^ sw1_rise;
    fast_d  = fast_q ^ sw2_rise;
    cnt_d   = cnt_q;
    state_d = state_q;
    pos_d   = pos_q;
    prev_d  = prev_q;
    pwm_d   = pwm_q + 1'b1;
    led_d   = '0;

    // A speed change restarts the step period so the new rate starts cleanly.
    if (sw2_rise || tick) begin
      cnt_d = '0;
    end else if (run_q) begin
      cnt_d = cnt_q + 1'b1;
    end

    if (tick) begin
      prev_d = pos_q;
      if (state_q == RIGHT) begin
        if (pos_q == POS_W'(NLEDS - 1)) begin
          pos_d   = POS_W'(NLEDS - 2);
          state_d = LEFT;
        end else begin
          pos_d = pos_q + 1'b1;
        end
      end else begin
        if (pos_q == '0) begin
          pos_d   = POS_W'(1);
          state_d = RIGHT;
        end else begin
          pos_d = pos_q - 1'b1;
        end
      end
    end

    for (int n = 0; n < NLEDS; n++) begin
      led_d[n] = (pos_q == POS_W'(n)) |
                 ((prev_q == POS_W'(n)) & (prev_q != pos_q) & (pwm_q == '0));
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      run_q   <= 1'b1;
      fast_q  <= 1'b0;
      cnt_q   <= '0;
      state_q <= RIGHT;
      pos_q   <= '0;
      prev_q  <= '0;
      pwm_q   <= '0;
      led_q   <= '0;
    end else begin
      run_q   <= run_d;
      fast_q  <= fast_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      pos_q   <= pos_d;
      prev_q  <= prev_d;
      pwm_q   <= pwm_d;
      led_q   <= led_d;
    end
  end

  assign LED0 = led_q[0];
  assign LED1 = led_q[1];
  assign LED2 = led_q[2];
  assign LED3 = led_q[3];
  assign LED4 = led_q[4];
  assign LED5 = led_q[5];
  assign LED6 = led_q[6];
  assign LED7 = led_q[7];
endmodule

// File: tb/tb_led_scanner.sv
// tb/tb_led_scanner.sv - randomized self-checking bench for led_scanner
module tb_led_scanner;
  localparam int DIV = 8;
  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       sw1 = 1'b0;
  logic       sw2 = 1'b0;
  logic [7:0] led;

  int checks = 0;
  int errors = 0;

  led_scanner #(.DIV(DIV), .DEB(DEB)) dut (
    .clk(clk), .rstn(rstn), .sw1(sw1), .sw2(sw2),
    .LED0(led[0]), .LED1(led[1]), .LED2(led[2]), .LED3(led[3]),
    .LED4(led[4]), .LED5(led[5]), .LED6(led[6]), .LED7(led[7])
  );

  always #5 clk = ~clk;

  // Reference: sweep index k, active-cycle count, and debounce judged on a sample window.
  bit         m_hist [2][DEB+2];
  bit         m_lvl [2];
  bit         m_r1 [2];
  bit         m_rise [2];
  bit         m_run, m_fast;
  int         m_active, m_k, m_edge;
  logic [7:0] m_exp;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sweep(input int k);
    int r;
    r = k % 14;
    return (r <= 7) ? r : 14 - r;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < DEB + 2; i++) m_hist[b][i] = 1'b0;
      m_lvl[b]  = 1'b0;
      m_r1[b]   = 1'b0;
      m_rise[b] = 1'b0;
    end
    m_run = 1'b1; m_fast = 1'b0;
    m_active = 0; m_k = 0; m_edge = 0;
  endtask

  task automatic model_edge(input bit b1, input bit b2);
    int pos, prev, p;
    bit tick, all_diff;
    bit pul [2];
    bit raw [2];
    if (!rstn) begin
      model_reset();
      m_exp = '0;
      return;
    end
    pos  = sweep(m_k);
    prev = (m_k == 0) ? 0 : sweep(m_k - 1);
    m_exp = 8'(1 << pos);
    if (m_k != 0 && m_edge % 4 == 0) m_exp[prev] = 1'b1;
    m_edge++;
    pul[0] = m_rise[0];
    pul[1] = m_rise[1];
    p = m_fast ? DIV / 4 : DIV;
    tick = 1'b0;
    if (m_run) begin
      m_active++;
      tick = (m_active % p == 0);
    end
    if (tick) m_k++;
    if (pul[1]) begin
      m_active = 0;
      m_fast = !m_fast;
    end
    if (pul[0]) m_run = !m_run;
    raw[0] = b1;
    raw[1] = b2;
    for (int b = 0; b < 2; b++) begin
      for (int i = DEB + 1; i > 0; i--) m_hist[b][i] = m_hist[b][i-1];
      m_hist[b][0] = raw[b];
      all_diff = 1'b1;
      for (int i = 2; i < DEB + 2; i++) if (m_hist[b][i] == m_lvl[b]) all_diff = 1'b0;
      m_rise[b] = m_r1[b];
      m_r1[b]   = all_diff && !m_lvl[b];
      if (all_diff) m_lvl[b] = !m_lvl[b];
    end
  endtask

  task automatic cyc(input bit b1, input bit b2);
    sw1 = b1;
    sw2 = b2;
    @(posedge clk);
    model_edge(b1, b2);
    @(negedge clk);
    chk("led", led, m_exp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0);
  endtask

  task automatic press(input int btn, input int n);
    for (int i = 0; i < n; i++) cyc(btn == 1, btn == 2);
    idle(4);
  endtask

  task automatic release_reset();
    rstn = 1'b1;
    cyc(1'b0, 1'b0);
    chk("rst_rel", led, 8'h01);
    for (int s = 1; s <= 3; s++) begin
      idle(DIV);
      chk("rel_step", led, 8'(1 << s) | ((m_edge % 4 == 1) ? 8'(1 << (s - 1)) : 8'h00));
    end
  endtask

  task automatic sw2_on_tick();
    bit found;
    int p;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      p = m_fast ? DIV / 4 : DIV;
      if (m_run && (m_active % p == 0)) begin
        found = 1'b1;
        break;
      end
      idle(1);
    end
    chk("align_sw2", 8'(found), 8'h01);
    press(2, 6);
  endtask

  initial begin
    bit found;
    int len;
    bit r1, r2;
    model_reset();
    @(negedge clk);
    idle(3);
    chk("in_reset", led, 8'h00);
    release_reset();

    idle(14 * DIV + 20);

    press(1, 6);
    idle(30);
    press(1, 6);
    idle(40);

    for (int g = 0; g < 6; g++) begin
      len = $urandom_range(1, 3);
      for (int i = 0; i < len; i++) cyc(1'b1, 1'b0);
      len = $urandom_range(1, 3);
      idle(len);
    end
    idle(8);
    press(1, 4);
    idle(20);
    press(1, 4);
    idle(20);

    sw2_on_tick();
    idle(20);
    sw2_on_tick();
    idle(20);
    sw2_on_tick();
    idle(20);
    sw2_on_tick();
    idle(20);

    for (int s = 0; s < 250; s++) begin
      r1 = ($urandom_range(0, 3) == 0);
      r2 = ($urandom_range(0, 3) == 0);
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) cyc(r1, r2);
    end
    idle(12);

    if (!m_run) press(1, 6);
    found = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (m_run && (m_k % 14 == 9)) begin
        found = 1'b1;
        break;
      end
      idle(1);
    end
    chk("find_pos5_left", 8'(found), 8'h01);
    #2;
    rstn = 1'b0;
    #1;
    chk("async_rst", led, 8'h00);
    model_reset();
    idle(2);
    release_reset();
    idle(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/led_scanner.md
# led_scanner

Drives the eight IceZUM LED pins with a bouncing "scanner" pattern: one LED fully lit, the previously lit LED glowing at 25 % duty as a trail. It sits directly upstream of the LED pins, replacing a constant all-on drive. Two push-buttons control it: SW1 toggles run/pause and SW2 toggles slow/fast speed.

## Interface
- DIV, 1_200_000 — slow step period in clk cycles (100 ms at 12 MHz); must be a multiple of 4 and ≥ 8
- DEB, 120_000 — debounce window in clk cycles (10 ms at 12 MHz); ≥ 2
- clk  in  1  system clock, the only clock
- rstn  in  1  reset, asynchronous, active-low
- sw1  in  1  run/pause button, active-high, asynchronous to clk
- sw2  in  1  speed button, active-high, asynchronous to clk
- LED0..LED7  out  1 each  LED drives, active-high; LEDn lit when the scanner position is n

## Operation
- **Button conditioning:** per button, apply a 2-flop synchronizer, then a debouncer.
  - Debounced level changes only after the synced input has differed from it for DEB consecutive cycles.
  - Any mismatch gap restarts the count.
  - A rising edge of the debounced level yields a 1-cycle pulse.
- **run:** reset value 1; toggles on each sw1 pulse.
- **fast:** reset value 0; toggles on each sw2 pulse.
- **Prescaler:**
  - Period P = DIV when slow, DIV/4 when fast.
  - The counter counts 0..P-1 only while run=1 and holds while run=0.
  - tick = run & (cnt == P-1); the counter wraps to 0 on tick.
  - A sw2 pulse clears the counter to 0 in the same cycle.
- **FSM:** states RIGHT and LEFT, plus a 3-bit pos and a 3-bit prev. Reset: RIGHT, pos=0, prev=0.
- On tick, prev ← pos, then:
  - RIGHT, pos<7: pos+1
  - RIGHT, pos==7: pos←6, go to LEFT
  - LEFT, pos>0: pos−1
  - LEFT, pos==0: pos←1, go to RIGHT
- **Trail PWM:** a free-running 2-bit counter pwm, reset 0, not gated by run. Trail is on when pwm==0.
- **Outputs (registered):** LEDn ← (pos==n) | (prev==n & prev≠pos & pwm==0).
- **Simultaneous events:**
  - tick and sw2 pulse in the same cycle: the step is applied and the counter is cleared.
  - sw1 pulse coinciding with tick: the tick (computed from the old run) is applied, and the pause holds from the next cycle.
  - sw1 and sw2 pulses together: both toggles apply.
- **Reset mid-operation:** all state returns to reset values immediately (asynchronous), including debouncer counters and the sync flops.

## Timing
- During reset, all LEDs are 0. The first clk edge after rstn rises loads LED0=1 and the others 0.
- Tick-to-LED latency: 1 cycle (the LED output register).
- Button latency: 2 sync cycles + DEB cycles + 1 edge cycle. The run/fast flags update on the following edge.
- Step interval: exactly P cycles between ticks while running. A pause then resume continues from the held count, so no cycles are lost or gained.
- Trail duty: 1 cycle in 4, phase set by the free-running pwm counter.
- Full sweep 0→7→0 takes 14 ticks; the end LEDs are lit for one tick per pass (no double-dwell).

## Structure
- **Shared package (led_pkg):**
  - NLEDS = 8 and POS_W = 3
  - State encoding: RIGHT = 1'b0, LEFT = 1'b1
  - PWM_W = 2
  - Default DIV/DEB constants
- **Sub-module btn_cond (params DEB):**
  - Ports: clk, rstn, in, level, rise.
  - Contains the synchronizer, debounce counter and edge detector.
  - Instantiated twice.
- The prescaler, FSM, PWM and output register live in the top module.

## Test plan
All scenarios use DIV=8 and DEB=4.
- **Reset release:** after rstn rises, LED0=1 and LED1..7=0 on the first edge. A tick every 8 cycles lights LED1, LED2, … in turn.
- **Bounce:** run 7 ticks to pos=7, then 1 more. Required: pos=6, state LEFT, LED7 lit only on pwm==0 cycles. After 6 more ticks pos=0, and the next tick gives pos=1, RIGHT.
- **Pause:**
  - Hold sw1 high for 6 cycles. Run clears 2+4+1+1 cycles after the press, and the LEDs freeze except the trail PWM.
  - A second press resumes. The remaining count completes, so total active cycles per step stay at 8.
- **Debounce:** toggle sw1 with glitches of 1–3 cycles. Required: no run change. Glitch-free high for 4 cycles: exactly one toggle.
- **Speed:** an sw2 press sets fast. The counter clears, and ticks then arrive every 2 cycles. A second press restores 8. Include a case with the sw2 pulse landing on a tick cycle: the step is taken and the counter is 0 next cycle.
- **Async reset mid-sweep:** assert rstn low between edges at pos=5, LEFT. Required: LEDs go 0 without waiting for a clock. On release, the pos=0, RIGHT, run=1, fast=0 behaviour is identical to the reset-release scenario.
